regfile_2r1w: RTL and testbench

Parametrised register file with two independent synchronous read ports and one write port, replacing the single-port read-or-write register array in the RISC-V datapath. It sits between decode (read addresses) and writeback (write port). A hardware clear sequencer zeroes every entry after reset or on request, and optional write-to-read bypass removes a stall cycle on same-cycle register reuse.

---
 rtl/regfile_2r1w_if.sv | 34 +++
 rtl/regfile_2r1w.sv | 92 +++++++++
 tb/tb_regfile_2r1w.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: decode-side read ports, writeback-side write port,
// clear request and ready. XLEN/NREGS must match the attached regfile_2r1w instance.
interface regfile_2r1w_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   // ready is the only flow control: while ready = 0 every request (reads, write, clr)
   // is ignored; while ready = 1 each request is accepted at the edge it is presented.
   logic            clr;
   logic            ready;
   logic            rd_en_a;
   logic [AW-1:0]   rd_addr_a;
   logic [XLEN-1:0] rdata_a;
   logic            rd_en_b;
   logic [AW-1:0]   rd_addr_b;
   logic [XLEN-1:0] rdata_b;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            dbg_run;
   logic [AW-1:0]   dbg_idx;

   modport master (
      output clr, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, wr_en, wr_addr, wr_data,
      input  ready, rdata_a, rdata_b, dbg_run, dbg_idx
   );

   modport slave (
      input  clr, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, wr_en, wr_addr, wr_data,
      output ready, rdata_a, rdata_b, dbg_run, dbg_idx
   );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with a post-reset clear sequencer.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-cycle read/write hazards.
module regfile_2r1w #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
   input  logic           clk,
   input  logic           reset,
   regfile_2r1w_if.slave  bus
);
   localparam int              AW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [AW:0]     NREGS_W  = (AW+1)'(NREGS);
   localparam logic [AW-1:0]   LAST_IDX = AW'(NREGS - 1);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   logic [XLEN-1:0] r_mem [NREGS];
   state_t          r_state;
   logic [AW-1:0]   r_idx;
   logic            r_ready;
   logic [XLEN-1:0] r_rdata_a;
   logic [XLEN-1:0] r_rdata_b;

   logic            w_wr_ok;
   logic [XLEN-1:0] w_rd_a;
   logic [XLEN-1:0] w_rd_b;

   // An address is live storage if it is in range and not the hardwired zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_comb begin
      w_wr_ok = bus.wr_en && !bus.clr && addr_ok(bus.wr_addr);
      w_rd_a  = '0;
      w_rd_b  = '0;
      if (addr_ok(bus.rd_addr_a)) w_rd_a = r_mem[bus.rd_addr_a];
      if (addr_ok(bus.rd_addr_b)) w_rd_b = r_mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (bus.rd_addr_a == bus.wr_addr)) w_rd_a = bus.wr_data;
      if (w_wr_ok && (bus.rd_addr_b == bus.wr_addr)) w_rd_b = bus.wr_data;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_idx     <= '0;
         r_ready   <= 1'b0;
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_rdata_a <= '0;
               r_rdata_b <= '0;
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
                  r_idx   <= '0;
               end else begin
                  r_idx <= r_idx + AW'(1);
               end
            end
            ST_RUN: begin
               if (bus.rd_en_a) r_rdata_a <= w_rd_a;
               if (bus.rd_en_b) r_rdata_b <= w_rd_b;
               if (bus.clr) begin
                  r_state <= ST_CLEAR;
                  r_idx   <= '0;
                  r_ready <= 1'b0;
               end
            end
         endcase
      end
   end

   // Storage has no reset; it is only zeroed by the clear walk once reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (r_state == ST_CLEAR) r_mem[r_idx] <= '0;
         else if (w_wr_ok)        r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.ready   = r_ready;
   assign bus.rdata_a = r_rdata_a;
   assign bus.rdata_b = r_rdata_b;
   assign bus.dbg_run = (r_state == ST_RUN);
   assign bus.dbg_idx = r_idx;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three instances (default, ZERO_REG=0, NREGS=20) share one
// stimulus stream and are compared each cycle against a behavioural array model.
module tb_regfile_2r1w;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clr = 1'b0, wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
   logic [4:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
   logic [31:0] wr_data = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_2r1w_if #(.XLEN(32), .NREGS(32)) if0 ();
   regfile_2r1w_if #(.XLEN(32), .NREGS(32)) if1 ();
   regfile_2r1w_if #(.XLEN(32), .NREGS(20)) if2 ();

   assign if0.clr = clr;  assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;  assign if0.wr_data = wr_data;
   assign if0.rd_en_a = rd_en_a;  assign if0.rd_addr_a = rd_addr_a;  assign if0.rd_en_b = rd_en_b;  assign if0.rd_addr_b = rd_addr_b;
   assign if1.clr = clr;  assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_data = wr_data;
   assign if1.rd_en_a = rd_en_a;  assign if1.rd_addr_a = rd_addr_a;  assign if1.rd_en_b = rd_en_b;  assign if1.rd_addr_b = rd_addr_b;
   assign if2.clr = clr;  assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr;  assign if2.wr_data = wr_data;
   assign if2.rd_en_a = rd_en_a;  assign if2.rd_addr_a = rd_addr_a;  assign if2.rd_en_b = rd_en_b;  assign if2.rd_addr_b = rd_addr_b;

   regfile_2r1w #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
   regfile_2r1w #(.XLEN(32), .NREGS(32), .ZERO_REG(0)) u1 (.clk(clk), .reset(reset), .bus(if1));
   regfile_2r1w #(.XLEN(32), .NREGS(20), .ZERO_REG(1)) u2 (.clk(clk), .reset(reset), .bus(if2));

   logic        rdy_o [3];
   logic [31:0] ra_o [3];
   logic [31:0] rb_o [3];
   assign rdy_o[0] = if0.ready;  assign ra_o[0] = if0.rdata_a;  assign rb_o[0] = if0.rdata_b;
   assign rdy_o[1] = if1.ready;  assign ra_o[1] = if1.rdata_a;  assign rb_o[1] = if1.rdata_b;
   assign rdy_o[2] = if2.ready;  assign ra_o[2] = if2.rdata_a;  assign rb_o[2] = if2.rdata_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          nr [3] = '{32, 32, 20};
   bit          zr [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m_mem [3][32];
   int          m_left [3];
   logic        m_ready [3];
   logic [31:0] m_ra [3];
   logic [31:0] m_rb [3];
   logic [194:0] exp_q [$];
   logic [194:0] snap;

   function automatic bit wr_ok(int k);
      return wr_en && !clr && (int'(wr_addr) < nr[k]) && !(zr[k] && wr_addr == 5'd0);
   endfunction

   function automatic logic [31:0] rd_val(int k, logic [4:0] a);
      if (int'(a) >= nr[k] || (zr[k] && a == 5'd0)) return 32'h0;
      if (BYP && wr_ok(k) && wr_addr == a) return wr_data;
      return m_mem[k][a];
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            m_left[k] = nr[k];  m_ready[k] = 1'b0;  m_ra[k] = '0;  m_rb[k] = '0;
         end else if (m_left[k] > 0) begin
            m_mem[k][nr[k] - m_left[k]] = '0;
            m_left[k]--;
            m_ra[k] = '0;  m_rb[k] = '0;
            if (m_left[k] == 0) m_ready[k] = 1'b1;
         end else begin
            if (rd_en_a) m_ra[k] = rd_val(k, rd_addr_a);
            if (rd_en_b) m_rb[k] = rd_val(k, rd_addr_b);
            if (clr) begin
               m_left[k] = nr[k];  m_ready[k] = 1'b0;
            end else if (wr_ok(k)) begin
               m_mem[k][wr_addr] = wr_data;
            end
         end
      end
      snap = {m_ready[0], m_ra[0], m_rb[0], m_ready[1], m_ra[1], m_rb[1], m_ready[2], m_ra[2], m_rb[2]};
      exp_q.push_back(snap);
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      logic [194:0] e;
      int base;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            base = (2 - k) * 65;
            chk($sformatf("ready[%0d]", k),   {31'd0, rdy_o[k]}, {31'd0, e[base + 64]});
            chk($sformatf("rdata_a[%0d]", k), ra_o[k], e[base + 32 +: 32]);
            chk($sformatf("rdata_b[%0d]", k), rb_o[k], e[base +: 32]);
         end
         chk("dbg_run0", {31'd0, if0.dbg_run}, {31'd0, e[194]});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic c, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ea, input logic [4:0] aa, input logic eb, input logic [4:0] ab);
      clr = c;  wr_en = we;  wr_addr = wa;  wr_data = wd;
      rd_en_a = ea;  rd_addr_a = aa;  rd_en_b = eb;  rd_addr_b = ab;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_ready(input int exp0, input int exp2);
      int n0 = 0;
      int n2 = 0;
      for (int n = 1; n <= 60; n++) begin
         idle(1);
         if (n0 == 0 && if0.ready) n0 = n;
         if (n2 == 0 && if2.ready) n2 = n;
         if (n0 != 0 && n2 != 0) break;
      end
      chk("clear_len_32", n0, exp0);
      chk("clear_len_20", n2, exp2);
   endtask

   function automatic logic [4:0] rnd_addr();
      return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
   endfunction

   initial begin
      @(negedge clk);
      idle(3);
      chk("rst_ready", {31'd0, if0.ready}, 32'd0);
      chk("rst_rdata_a", if0.rdata_a, 32'd0);
      chk("rst_rdata_b", if0.rdata_b, 32'd0);
      reset = 1'b1;
      wait_ready(32, 20);

      // Garbage pre-load, reset pulse, then every entry must read back as zero.
      for (int a = 0; a < 32; a++) cyc(0, 1, 5'(a), $urandom, 0, 0, 0, 0);
      reset = 1'b0;
      idle(3);
      reset = 1'b1;
      wait_ready(32, 20);
      for (int a = 0; a < 32; a++) begin
         cyc(0, 0, 0, 0, 1, 5'(a), 1, 5'(a));
         chk("clr_rd_a", if0.rdata_a, 32'h0);
         chk("clr_rd_b", if0.rdata_b, 32'h0);
      end

      cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc(0, 1, 31, 32'h12345678, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 5, 1, 31);
      chk("wr_rd_a", if0.rdata_a, 32'hDEADBEEF);
      chk("wr_rd_b", if0.rdata_b, 32'h12345678);
      idle(2);
      chk("hold_a", if0.rdata_a, 32'hDEADBEEF);
      chk("hold_b", if0.rdata_b, 32'h12345678);

      cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 1, 0);
      chk("x0_a", if0.rdata_a, 32'h0);
      chk("x0_b", if0.rdata_b, 32'h0);
      chk("r0_plain_a", if1.rdata_a, 32'hFFFFFFFF);
      chk("r0_plain_b", if1.rdata_b, 32'hFFFFFFFF);

      cyc(0, 1, 7, 32'h11, 0, 0, 0, 0);
      cyc(0, 1, 7, 32'h22, 1, 7, 0, 0);
      chk("hazard_a", if0.rdata_a, BYP ? 32'h22 : 32'h11);
      cyc(0, 0, 0, 0, 1, 7, 0, 0);
      chk("hazard_next", if0.rdata_a, 32'h22);

      cyc(0, 1, 3, 32'h77, 0, 0, 0, 0);
      cyc(1, 1, 3, 32'hAB, 0, 0, 0, 0);
      chk("clr_ready_fall", {31'd0, if0.ready}, 32'd0);
      cyc(0, 1, 3, 32'h55, 0, 0, 0, 0);
      wait_ready(31, 19);
      cyc(0, 0, 0, 0, 1, 3, 1, 3);
      chk("clr_r3", if0.rdata_a, 32'h0);

      // Reset lands part-way through the clear walk.
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(10);
      reset = 1'b0;
      idle(1);
      chk("midclr_idx", {27'd0, if2.dbg_idx}, 32'd0);
      chk("midclr_ready", {31'd0, if2.ready}, 32'd0);
      idle(1);
      reset = 1'b1;
      wait_ready(32, 20);

      cyc(0, 1, 25, 32'hCAFEF00D, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 25, 1, 25);
      chk("oob_rd_20", if2.rdata_a, 32'h0);
      chk("inrange_rd_32", if0.rdata_a, 32'hCAFEF00D);

      repeat (1500) begin
         cyc($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
             1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr());
      end
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
